// File: rtl/rr_stream_arb.sv
// Round-robin arbiter merging NUM_REQ valid/ready streams into one registered output stream.
// Optional packet locking (hold grant until in_last) enabled by defining RR_STREAM_ARB_PKT_LOCK_EN.
module rr_stream_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 256,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            in_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_REQ-1:0]            in_last,
  output logic [NUM_REQ-1:0]            in_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_last,
  output logic [ID_W-1:0]               out_id,
  input  logic                          out_ready
);

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic                  out_last_q,  out_last_d;
  logic [ID_W-1:0]       out_id_q,    out_id_d;
  logic [ID_W-1:0]       rr_ptr_q,    rr_ptr_d;
`ifdef RR_STREAM_ARB_PKT_LOCK_EN
  logic                  lock_q,      lock_d;
  logic [ID_W-1:0]       lock_id_q,   lock_id_d;
`endif

  logic                  load_en;
  logic                  accept;
  logic [NUM_REQ-1:0]    grant;
  logic                  gnt_valid;
  logic [ID_W-1:0]       gnt_id;
  logic [ID_W-1:0]       base;
  logic [ID_W-1:0]       ptr_inc;

  // Search upward from the base index; while locked only the locked requester (k == 0) may win.
  always_comb begin
    load_en   = !out_valid_q || out_ready;
    grant     = '0;
    gnt_valid = 1'b0;
    gnt_id    = '0;
    base      = rr_ptr_q;
`ifdef RR_STREAM_ARB_PKT_LOCK_EN
    if (lock_q) base = lock_id_q;
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      int              s;
      logic [ID_W-1:0] idx;
      logic            cand;
      s = int'(base) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      idx = s[ID_W-1:0];
`ifdef RR_STREAM_ARB_PKT_LOCK_EN
      cand = in_valid[idx] && (k == 0 || !lock_q);
`else
      cand = in_valid[idx];
`endif
      if (!gnt_valid && cand) begin
        gnt_valid  = 1'b1;
        gnt_id     = idx;
        grant[idx] = 1'b1;
      end
    end
  end

  assign in_ready = reset ? '0 : (grant & {NUM_REQ{load_en}});
  assign accept   = gnt_valid && load_en && !reset;
  assign ptr_inc  = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_id_d    = out_id_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef RR_STREAM_ARB_PKT_LOCK_EN
    lock_d      = lock_q;
    lock_id_d   = lock_id_q;
`endif
    if (load_en) out_valid_d = accept;
    if (accept) begin
      out_data_d = in_data[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
      out_last_d = in_last[gnt_id];
      out_id_d   = gnt_id;
`ifdef RR_STREAM_ARB_PKT_LOCK_EN
      // Pointer stays frozen for the whole packet and advances past the owner on its last beat.
      if (in_last[gnt_id]) begin
        lock_d   = 1'b0;
        rr_ptr_d = ptr_inc;
      end else begin
        lock_d    = 1'b1;
        lock_id_d = gnt_id;
      end
`else
      rr_ptr_d = ptr_inc;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
`ifdef RR_STREAM_ARB_PKT_LOCK_EN
      lock_q      <= 1'b0;
      lock_id_q   <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef RR_STREAM_ARB_PKT_LOCK_EN
      lock_q      <= lock_d;
      lock_id_q   <= lock_id_d;
`endif
    end
  end

  // Payload registers need no reset; they are only meaningful while out_valid is high.
  always_ff @(posedge clk) begin
    out_data_q <= out_data_d;
    out_last_q <= out_last_d;
    out_id_q   <= out_id_d;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_rr_stream_arb.sv
// Directed bench for rr_stream_arb: vector table for per-beat arbitration and hold,
// plus hand sequences for packet interleave/lock, gaps and reset with a held beat.
module tb_rr_stream_arb;

  localparam int NR = 4;
  localparam int DW = 256;

  logic              clk;
  logic              reset;
  logic [NR-1:0]     in_valid;
  logic [NR*DW-1:0]  in_data;
  logic [NR-1:0]     in_last;
  logic [NR-1:0]     in_ready;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic              out_last;
  logic [1:0]        out_id;
  logic              out_ready;

  int n_cmp  = 0;
  int n_fail = 0;

  rr_stream_arb #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic       ordy;
    logic [3:0] rdy;
    logic       ov;
    logic [1:0] id;
    logic [7:0] src;
  } vec_t;

  vec_t tbl[21];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tag_data(input int k);
    for (int i = 0; i < NR; i++) in_data[i*DW +: DW] = DW'((k << 4) | i);
  endtask

  // Req0 sends a 3-beat packet (optionally with a valid gap after beat 1); req1 always valid.
  task automatic run_pkt(input string nm, input int gap_len, input logic [7:0] e_ov,
                         input logic [15:0] e_id);
    int  beats;
    int  acc;
    int  gapc;
    logic v0;
    logic [1:0] eid;
    @(negedge clk);
    reset = 1'b1; in_valid = '0; in_last = '1; out_ready = 1'b1;
    beats = 3; acc = 0; gapc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      reset = 1'b0;
      v0 = (beats > 0) && !(acc == 1 && gapc < gap_len);
      if (acc == 1 && gapc < gap_len) gapc++;
      in_valid = {2'b00, 1'b1, v0};
      in_last  = {3'b111, (beats == 1)};
      tag_data(100 + c);
      #1;
      eid = e_id[2*c +: 2];
      $display("%s c%0d: ov=%b id=%0d rdy=%b", nm, c, out_valid, out_id, in_ready);
      chk($sformatf("%s c%0d out_valid", nm, c), 64'(out_valid), 64'(e_ov[c]));
      if (e_ov[c]) chk($sformatf("%s c%0d out_id", nm, c), 64'(out_id), 64'(eid));
      if (in_ready[0]) begin
        beats--;
        acc++;
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = '0; in_last = '1; out_ready = 1'b1; in_data = '0;
    // rst vld ordy | rdy ov id src
    tbl[0]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 8'd0};
    tbl[1]  = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b0, 2'd0, 8'd0};
    tbl[2]  = '{1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd0, 8'd1};
    tbl[3]  = '{1'b0, 4'hF, 1'b1, 4'h4, 1'b1, 2'd1, 8'd2};
    tbl[4]  = '{1'b0, 4'hF, 1'b1, 4'h8, 1'b1, 2'd2, 8'd3};
    tbl[5]  = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd3, 8'd4};
    tbl[6]  = '{1'b0, 4'h8, 1'b1, 4'h8, 1'b1, 2'd0, 8'd5};
    tbl[7]  = '{1'b0, 4'h1, 1'b1, 4'h1, 1'b1, 2'd3, 8'd6};
    tbl[8]  = '{1'b0, 4'h2, 1'b1, 4'h2, 1'b1, 2'd0, 8'd7};
    tbl[9]  = '{1'b0, 4'h1, 1'b1, 4'h1, 1'b1, 2'd1, 8'd8};
    tbl[10] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 2'd0, 8'd9};
    tbl[11] = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 8'd9};
    tbl[12] = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 8'd9};
    tbl[13] = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 8'd9};
    tbl[14] = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 8'd9};
    tbl[15] = '{1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd0, 8'd9};
    tbl[16] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 2'd1, 8'd15};
    tbl[17] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 8'd0};
    tbl[18] = '{1'b0, 4'h4, 1'b0, 4'h4, 1'b0, 2'd0, 8'd0};
    tbl[19] = '{1'b0, 4'h4, 1'b0, 4'h0, 1'b1, 2'd2, 8'd18};
    tbl[20] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 2'd2, 8'd18};

    repeat (2) @(negedge clk);

    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      reset     = tbl[k].rst;
      in_valid  = tbl[k].vld;
      in_last   = '1;
      out_ready = tbl[k].ordy;
      tag_data(k);
      #1;
      $display("vec %0d: rdy=%b ov=%b id=%0d data=%0h", k, in_ready, out_valid, out_id, out_data[31:0]);
      chk($sformatf("vec%0d in_ready", k), 64'(in_ready), 64'(tbl[k].rdy));
      chk($sformatf("vec%0d out_valid", k), 64'(out_valid), 64'(tbl[k].ov));
      if (tbl[k].ov) begin
        chk($sformatf("vec%0d out_id", k), 64'(out_id), 64'(tbl[k].id));
        chk($sformatf("vec%0d out_data", k), out_data[63:0],
            64'((int'(tbl[k].src) << 4) | int'(tbl[k].id)));
        chk($sformatf("vec%0d out_last", k), 64'(out_last), 64'd1);
      end
    end

`ifdef RR_STREAM_ARB_PKT_LOCK_EN
    run_pkt("lock", 0, 8'b1111_1110,
            {2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0});
    run_pkt("lockgap", 2, 8'b1111_0010,
            {2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0});
`else
    run_pkt("ilv", 0, 8'b1111_1110,
            {2'd1, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0});
    run_pkt("ilvgap", 2, 8'b1111_1110,
            {2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0});
`endif

    // Held 0xA5 beat, possibly mid-packet, then reset discards it and clears any lock.
    @(negedge clk);
    reset = 1'b1; in_valid = '0; out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0; in_valid = 4'b0001; in_last = 4'b1110; out_ready = 1'b0;
    in_data = '0; in_data[0 +: DW] = DW'(8'hA5); in_data[DW +: DW] = DW'(8'h5A);
    #1;
    $display("rst seq accept: rdy=%b ov=%b", in_ready, out_valid);
    chk("rstseq first rdy", 64'(in_ready), 64'h1);
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      in_valid = 4'b0011;
      #1;
      $display("rst seq hold %0d: rdy=%b ov=%b data=%0h", h, in_ready, out_valid, out_data[31:0]);
      chk($sformatf("hold%0d out_valid", h), 64'(out_valid), 64'd1);
      chk($sformatf("hold%0d out_data", h), out_data[63:0], 64'hA5);
      chk($sformatf("hold%0d in_ready", h), 64'(in_ready), 64'h0);
    end
    @(negedge clk);
    reset = 1'b1; in_valid = 4'hF;
    #1;
    $display("rst seq in reset: rdy=%b", in_ready);
    chk("reset forces in_ready", 64'(in_ready), 64'h0);
    @(negedge clk);
    reset = 1'b0; in_valid = 4'b0110; in_last = 4'hF; out_ready = 1'b1;
    #1;
    $display("rst seq after: rdy=%b ov=%b", in_ready, out_valid);
    chk("post-reset out_valid", 64'(out_valid), 64'd0);
    chk("post-reset grant", 64'(in_ready), 64'h2);
    @(negedge clk);
    in_valid = '0;
    #1;
    $display("rst seq out: ov=%b id=%0d", out_valid, out_id);
    chk("post-reset out_valid2", 64'(out_valid), 64'd1);
    chk("post-reset out_id", 64'(out_id), 64'd1);
    chk("post-reset out_data", out_data[63:0], 64'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_stream_arb.md
RR_STREAM_ARB -- requirements
Module: rr_stream_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesting streams (range 2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 256, payload width per beat.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  NUM_REQ  per-requester beat valid.
REQ-006 SHALL have port in_data  input  NUM_REQ*DATA_WIDTH  requester i payload at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port in_last  input  NUM_REQ  per-requester end-of-packet flag.
REQ-008 SHALL have port in_ready  output  NUM_REQ  per-requester beat accept.
REQ-009 SHALL have port out_valid  output  1  shared-stream beat valid.
REQ-010 SHALL have port out_data  output  DATA_WIDTH  shared-stream payload.
REQ-011 SHALL have port out_last  output  1  end-of-packet flag of the output beat.
REQ-012 SHALL have port out_id  output  max(1,$clog2(NUM_REQ))  index of the requester that sourced the output beat.
REQ-013 SHALL have port out_ready  input  1  downstream accept.

Function
REQ-014 Transfer SHALL occur on any port when valid and ready are both high at a rising clk edge.
REQ-015 Output SHALL be one register stage (out_valid/out_data/out_last/out_id registered); load_en = !out_valid | out_ready.
REQ-016 Accepted input beat SHALL appear on out_* exactly 1 cycle after acceptance; sustained throughput 1 beat/cycle.
REQ-017 Held beat (out_valid & !out_ready) SHALL keep out_data/out_last/out_id stable.
REQ-018 Grant SHALL select the first i with in_valid[i]=1, searching from rr_ptr upward modulo NUM_REQ (wrap NUM_REQ-1 -> 0).
REQ-019 in_ready[i] SHALL equal grant[i] & load_en; at most one in_ready bit high per cycle; in_ready SHALL not depend on out_ready except through load_en.
REQ-020 On acceptance from requester i, rr_ptr SHALL become (i+1) mod NUM_REQ; no acceptance -> rr_ptr unchanged.
REQ-021 No in_valid high or load_en low SHALL produce no acceptance and no state change except output drain.
REQ-022 Simultaneous output drain and new acceptance SHALL replace the output register in the same edge, no bubble.
REQ-023 in_valid of a non-granted requester SHALL have no effect on outputs.

Reset
REQ-024 While reset=1: out_valid=0, rr_ptr=0, lock state cleared, all in_ready=0 (combinationally forced).
REQ-025 reset asserted mid-packet or with held output beat SHALL discard that beat; out_data/out_last/out_id values undefined while out_valid=0.
REQ-026 First edge after reset deasserts SHALL arbitrate from requester 0.

Configuration
REQ-027 Macro RR_STREAM_ARB_PKT_LOCK_EN defined: after accepting a beat with in_last=0 from i, grant SHALL stay locked to i (other in_valid ignored, rr_ptr frozen) until a beat with in_last=1 from i is accepted; then rr_ptr=(i+1) mod NUM_REQ.
REQ-028 With lock and locked requester's in_valid low, output SHALL bubble; no other requester granted.
REQ-029 Macro undefined: arbitration per beat per REQ-018/020; in_last only forwarded to out_last.

Verification
REQ-030 All 4 in_valid=1 continuously, single-beat packets (last=1), out_ready=1 -> out_id sequence 0,1,2,3,0,... one beat/cycle, first out_valid 1 cycle after reset release.
REQ-031 Only requester 3 valid, then requester 0 valid -> out_id 3 then 0 (pointer wrap 3->0).
REQ-032 out_ready=0 for 5 cycles with beat 0xA5 held -> out_data=0xA5 stable, all in_ready=0 throughout, no beat lost or duplicated.
REQ-033 LOCK_EN: req0 sends 3-beat packet (last on beat 3), req1 valid throughout -> out_id 0,0,0,1; req0 valid gap of 2 cycles mid-packet -> 2 bubbles, req1 not granted.
REQ-034 LOCK_EN undefined, same stimulus -> out_id 0,1,0,1,0 interleaved.
REQ-035 reset pulsed with held output and locked packet -> out_valid=0 next cycle, lock cleared, next grant to lowest valid index from 0.
